// File: rtl/kf_seq_pkg.sv
// Shared types for the Kalman filter run sequencer: FSM states, stage codes
// and the default watchdog limit.
package kf_seq_pkg;

    localparam int unsigned KF_SEQ_DEFAULT_TIMEOUT = 4096;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_SP,
        S_CKG,
        S_WAIT_MEAS,
        S_SCU,
        S_SCO,
        S_DONE,
        S_ERR
    } kf_seq_state_t;

    typedef enum logic [2:0] {
        STG_NONE = 3'd0,
        STG_INIT = 3'd1,
        STG_SP   = 3'd2,
        STG_CKG  = 3'd3,
        STG_SCU  = 3'd4
    } kf_stage_e;

    function automatic kf_stage_e stage_of(input kf_seq_state_t s);
        case (s)
            S_INIT:  return STG_INIT;
            S_SP:    return STG_SP;
            S_CKG:   return STG_CKG;
            S_SCU:   return STG_SCU;
            default: return STG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/kf_stage_watchdog.sv
// Per-stage cycle counter: cleared on stage entry, counts while the stage is
// active and flags expiry once it reaches LIMIT.
module kf_stage_watchdog #(
    parameter int unsigned TO_W  = 16,
    parameter int unsigned LIMIT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT_V = TO_W'(LIMIT);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + TO_W'(1);
        end
    end

    assign expired = (cnt == LIMIT_V);

endmodule

// File: rtl/kf_sequencer.sv
// Run-level controller for the Kalman filter core: sequences stage enables,
// gates the update on measurement availability, counts iterations, watchdogs stages.
module kf_sequencer
    import kf_seq_pkg::*;
#(
    parameter int unsigned ITER_W         = 16,
    parameter int unsigned TO_W           = 16,
    parameter int unsigned TIMEOUT_CYCLES = KF_SEQ_DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ITER_W-1:0] num_iter,
    input  logic              meas_valid,
    output logic              meas_ready,
    output logic              en_init,
    output logic              en_sp,
    output logic              en_ckg,
    output logic              en_scu,
    output logic              en_sco,
    input  logic              init_done,
    input  logic              sp_done,
    input  logic              ckg_done,
    input  logic              scu_s_done,
    input  logic              scu_p_done,
    output logic              busy,
    output logic              filter_done,
    output logic              error,
    output logic [2:0]        err_stage,
    output logic [ITER_W-1:0] iter_cnt
);

    kf_seq_state_t     state_q, state_d;
    logic              entry_q;
    logic              s_seen, p_seen;
    logic [ITER_W-1:0] num_lat;
    logic [ITER_W-1:0] iter_q;
    kf_stage_e         err_q;
    logic              timeout;
    logic              wd_clear, wd_enable, wd_expired;
    logic              scu_both;
    logic              last_iter;

    assign wd_clear  = (state_d != state_q) &&
                       (state_d inside {S_INIT, S_SP, S_CKG, S_SCU});
    assign wd_enable = state_q inside {S_INIT, S_SP, S_CKG, S_SCU};

    kf_stage_watchdog #(
        .TO_W  (TO_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    assign scu_both  = (s_seen | scu_s_done) & (p_seen | scu_p_done);
    assign last_iter = (num_lat != '0) && ((iter_q + ITER_W'(1)) == num_lat);

    // Done pulses in a stage's entry cycle belong to no request, so entry_q masks them.
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) state_d = S_INIT;
            end
            S_INIT: begin
                if (abort)                       state_d = S_IDLE;
                else if (init_done && !entry_q)  state_d = S_SP;
                else if (wd_expired) begin
                    state_d = S_ERR;
                    timeout = 1'b1;
                end
            end
            S_SP: begin
                if (abort)                       state_d = S_IDLE;
                else if (sp_done && !entry_q)    state_d = S_CKG;
                else if (wd_expired) begin
                    state_d = S_ERR;
                    timeout = 1'b1;
                end
            end
            S_CKG: begin
                if (abort)                       state_d = S_IDLE;
                else if (ckg_done && !entry_q)   state_d = S_WAIT_MEAS;
                else if (wd_expired) begin
                    state_d = S_ERR;
                    timeout = 1'b1;
                end
            end
            S_WAIT_MEAS: begin
                if (abort)                       state_d = S_IDLE;
                else if (meas_valid)             state_d = S_SCU;
            end
            S_SCU: begin
                if (abort)                       state_d = S_IDLE;
                else if (scu_both && !entry_q)   state_d = S_SCO;
                else if (wd_expired) begin
                    state_d = S_ERR;
                    timeout = 1'b1;
                end
            end
            S_SCO: begin
                if (abort)                       state_d = S_IDLE;
                else if (last_iter)              state_d = S_DONE;
                else                             state_d = S_SP;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR: begin
                if (abort)                       state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            entry_q <= 1'b0;
            s_seen  <= 1'b0;
            p_seen  <= 1'b0;
            num_lat <= '0;
            iter_q  <= '0;
            err_q   <= STG_NONE;
        end else begin
            state_q <= state_d;
            entry_q <= (state_d != state_q);

            if (state_q == S_SCU && state_d == S_SCU) begin
                s_seen <= s_seen | (scu_s_done & ~entry_q);
                p_seen <= p_seen | (scu_p_done & ~entry_q);
            end else begin
                s_seen <= 1'b0;
                p_seen <= 1'b0;
            end

            if (state_q == S_IDLE && state_d == S_INIT) begin
                num_lat <= num_iter;
                iter_q  <= '0;
            end else if (state_q == S_SCO) begin
                iter_q  <= iter_q + ITER_W'(1);
            end

            if (timeout) begin
                err_q <= stage_of(state_q);
            end else if (state_q == S_ERR && abort) begin
                err_q <= STG_NONE;
            end
        end
    end

    always_comb begin
        en_init     = (state_q == S_INIT) && entry_q;
        en_sp       = (state_q == S_SP)   && entry_q;
        en_ckg      = (state_q == S_CKG)  && entry_q;
        en_scu      = (state_q == S_SCU)  && entry_q;
        en_sco      = (state_q == S_SCO);
        meas_ready  = (state_q == S_WAIT_MEAS) && meas_valid && !abort;
        busy        = (state_q != S_IDLE);
        filter_done = (state_q == S_DONE);
        error       = (state_q == S_ERR);
        err_stage   = err_q;
        iter_cnt    = iter_q;
    end

endmodule

// File: tb/tb_kf_sequencer.sv
// Scoreboard bench for kf_sequencer: expected pulse events are queued with
// their cycle numbers and matched against every observed output pulse.
module tb_kf_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] num_iter;
    logic        meas_valid;
    logic        meas_ready;
    logic        en_init, en_sp, en_ckg, en_scu, en_sco;
    logic        init_done, sp_done, ckg_done, scu_s_done, scu_p_done;
    logic        busy, filter_done, error;
    logic [2:0]  err_stage;
    logic [15:0] iter_cnt;

    kf_sequencer #(
        .ITER_W         (16),
        .TO_W           (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .num_iter    (num_iter),
        .meas_valid  (meas_valid),
        .meas_ready  (meas_ready),
        .en_init     (en_init),
        .en_sp       (en_sp),
        .en_ckg      (en_ckg),
        .en_scu      (en_scu),
        .en_sco      (en_sco),
        .init_done   (init_done),
        .sp_done     (sp_done),
        .ckg_done    (ckg_done),
        .scu_s_done  (scu_s_done),
        .scu_p_done  (scu_p_done),
        .busy        (busy),
        .filter_done (filter_done),
        .error       (error),
        .err_stage   (err_stage),
        .iter_cnt    (iter_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int code;
        int at;
    } ev_t;
    ev_t exp_q[$];

    // Stage unit model: returns done d_* cycles after each enable.
    int d_init = 2, d_sp = 2, d_ckg = 2, d_s = 2, d_p = 2;
    bit on_init = 1, on_sp = 1, on_ckg = 1, on_s = 1, on_p = 1;
    int t_init = -1, t_sp = -1, t_ckg = -1, t_s = -1, t_p = -1;

    function automatic string nm(input int c);
        case (c)
            1: return "en_init";
            2: return "en_sp";
            3: return "en_ckg";
            4: return "meas_ready";
            5: return "en_scu";
            6: return "en_sco";
            7: return "filter_done";
            default: return "none";
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        logic [6:0] p;
        ev_t e;
        p = {filter_done, en_sco, en_scu, meas_ready, en_ckg, en_sp, en_init};
        for (int i = 0; i < 7; i++) begin
            if (p[i] === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pulse_seq: got %s@%0d, required no pulse", nm(i + 1), cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.code !== i + 1 || e.at !== cyc) begin
                        bad++;
                        $display("FAIL pulse_seq: got %s@%0d, required %s@%0d",
                                 nm(i + 1), cyc, nm(e.code), e.at);
                    end
                end
            end
        end
        if (rst) begin
            t_init = -1; t_sp = -1; t_ckg = -1; t_s = -1; t_p = -1;
        end else begin
            if (en_init && on_init) t_init = cyc + d_init;
            if (en_sp && on_sp)     t_sp   = cyc + d_sp;
            if (en_ckg && on_ckg)   t_ckg  = cyc + d_ckg;
            if (en_scu && on_s)     t_s    = cyc + d_s;
            if (en_scu && on_p)     t_p    = cyc + d_p;
        end
    end

    always @(posedge clk) begin
        #1;
        init_done  = (cyc == t_init);
        sp_done    = (cyc == t_sp);
        ckg_done   = (cyc == t_ckg);
        scu_s_done = (cyc == t_s);
        scu_p_done = (cyc == t_p);
    end

    task automatic push(input int code, input int at);
        ev_t e;
        e.code = code;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // One iteration with 2-cycle stages and measurement available; base = SP entry.
    task automatic push_iter(input int base);
        push(2, base);
        push(3, base + 3);
        push(4, base + 6);
        push(5, base + 7);
        push(6, base + 10);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(input logic [15:0] n, output int t0);
        t0       = cyc;
        start    = 1'b1;
        num_iter = n;
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    task automatic flush_check(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: got %0d expected pulses never seen, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0; num_iter = '0; meas_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || error !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got busy=%b error=%b, required 0 0", busy, error);
        end
        total++;
        if (err_stage !== 3'd0 || iter_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_counts: got err_stage=%0d iter_cnt=%0d, required 0 0", err_stage, iter_cnt);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_nominal;
        int t0;
        meas_valid = 1'b1;
        go(16'd2, t0);
        push(1, t0 + 1);
        push_iter(t0 + 4);
        push_iter(t0 + 15);
        push(7, t0 + 26);
        wait_cyc(t0 + 24);
        total++;
        if (busy !== 1'b1 || iter_cnt !== 16'd1) begin
            bad++;
            $display("FAIL nominal_mid: got busy=%b iter_cnt=%0d, required 1 1", busy, iter_cnt);
        end
        wait_cyc(t0 + 27);
        total++;
        if (busy !== 1'b0 || iter_cnt !== 16'd2) begin
            bad++;
            $display("FAIL nominal_end: got busy=%b iter_cnt=%0d, required 0 2", busy, iter_cnt);
        end
        wait_cyc(t0 + 30);
        flush_check("nominal_events");
    endtask

    task automatic test_meas_stall;
        int t0;
        meas_valid = 1'b0;
        go(16'd1, t0);
        push(1, t0 + 1);
        push(2, t0 + 4);
        push(3, t0 + 7);
        wait_cyc(t0 + 29);
        total++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL stall_wait: got error=%b busy=%b, required 0 1", error, busy);
        end
        wait_cyc(t0 + 30);
        meas_valid = 1'b1;
        push(4, t0 + 30);
        push(5, t0 + 31);
        push(6, t0 + 34);
        push(7, t0 + 35);
        wait_cyc(t0 + 38);
        total++;
        if (iter_cnt !== 16'd1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stall_end: got iter_cnt=%0d busy=%b, required 1 0", iter_cnt, busy);
        end
        flush_check("stall_events");
    endtask

    task automatic test_scu_order;
        int t0;
        meas_valid = 1'b1;
        d_s = 7;
        go(16'd2, t0);
        push(1, t0 + 1);
        push(2, t0 + 4);
        push(3, t0 + 7);
        push(4, t0 + 10);
        push(5, t0 + 11);
        push(6, t0 + 19);
        push(2, t0 + 20);
        push(3, t0 + 23);
        push(4, t0 + 26);
        push(5, t0 + 27);
        push(6, t0 + 30);
        push(7, t0 + 31);
        wait_cyc(t0 + 12);
        d_s = 2;
        wait_cyc(t0 + 34);
        total++;
        if (iter_cnt !== 16'd2 || error !== 1'b0) begin
            bad++;
            $display("FAIL scu_order_end: got iter_cnt=%0d error=%b, required 2 0", iter_cnt, error);
        end
        flush_check("scu_order_events");
    endtask

    task automatic test_timeout;
        int t0;
        on_ckg = 1'b0;
        go(16'd1, t0);
        push(1, t0 + 1);
        push(2, t0 + 4);
        push(3, t0 + 7);
        wait_cyc(t0 + 15);
        total++;
        if (error !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early: got error=%b, required 0", error);
        end
        wait_cyc(t0 + 16);
        total++;
        if (error !== 1'b1 || err_stage !== 3'd3) begin
            bad++;
            $display("FAIL timeout_fire: got error=%b err_stage=%0d, required 1 3", error, err_stage);
        end
        wait_cyc(t0 + 18);
        start = 1'b1;
        num_iter = 16'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_cyc(t0 + 20);
        total++;
        if (error !== 1'b1 || err_stage !== 3'd3) begin
            bad++;
            $display("FAIL timeout_start_ignored: got error=%b err_stage=%0d, required 1 3", error, err_stage);
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        total++;
        if (error !== 1'b0 || err_stage !== 3'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_abort: got error=%b err_stage=%0d busy=%b, required 0 0 0",
                     error, err_stage, busy);
        end
        on_ckg = 1'b1;
        wait_cyc(t0 + 24);
        flush_check("timeout_events");
    endtask

    task automatic test_abort_mid;
        int t0;
        meas_valid = 1'b1;
        go(16'd2, t0);
        push(1, t0 + 1);
        push(2, t0 + 4);
        wait_cyc(t0 + 6);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: got busy=%b, required 0", busy);
        end
        wait_cyc(t0 + 14);
        total++;
        if (iter_cnt !== 16'd0 || error !== 1'b0) begin
            bad++;
            $display("FAIL abort_state: got iter_cnt=%0d error=%b, required 0 0", iter_cnt, error);
        end
        flush_check("abort_events");
    endtask

    task automatic test_continuous_reset;
        int t0;
        meas_valid = 1'b1;
        go(16'd0, t0);
        push(1, t0 + 1);
        for (int k = 0; k < 50; k++) push_iter(t0 + 4 + 11 * k);
        push(2, t0 + 554);
        push(3, t0 + 557);
        push(4, t0 + 560);
        push(5, t0 + 561);
        wait_cyc(t0 + 560);
        total++;
        if (iter_cnt !== 16'd50 || busy !== 1'b1) begin
            bad++;
            $display("FAIL continuous_count: got iter_cnt=%0d busy=%b, required 50 1", iter_cnt, busy);
        end
        wait_cyc(t0 + 562);
        rst = 1'b1;
        #1;
        total++;
        if ({busy, error, filter_done, meas_ready, en_init, en_sp, en_ckg, en_scu, en_sco} !== 9'd0 ||
            err_stage !== 3'd0 || iter_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_in_scu: got busy=%b en_scu=%b iter_cnt=%0d, required all 0",
                     busy, en_scu, iter_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cyc(t0 + 568);
        flush_check("continuous_events");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_meas_stall();
        test_scu_order();
        test_timeout();
        test_abort_mid();
        test_continuous_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no completion, required completion");
        $fatal(1, "simulation time limit");
    end

endmodule
